riscv_pipeline: RTL and testbench

Five-stage in-order pipelined RV32I-subset processor (IF, ID, EX, MEM, WB) with on-chip instruction ROM and data RAM. This is the FPGA top-level core. Two selector inputs choose which internal values drive the 8 board LEDs and the 13-bit seven-segment display value.

---
 rtl/riscv_pkg.sv | 97 +++++++++
 rtl/riscv_regfile.sv | 26 ++
 rtl/riscv_pipeline.sv | 195 +++++++++++++++++++
 tb/tb_riscv_pipeline.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings, control bundle and pipeline-register types for riscv_pipeline.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT
  } alu_op_e;

  // aluop: 00 add (addresses), 01 sub (compare), 10 R-type, 11 I-type
  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic       jump;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
`ifdef FORWARD_EN
    logic [4:0]  rs1;
    logic [4:0]  rs2;
`endif
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
  } idex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic [31:0] res;
    logic [31:0] rs2d;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } memwb_t;

  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [2:0] f3,
                                         input logic f7b5);
    alu_decode = ALU_ADD;
    if (aluop == 2'b01) alu_decode = ALU_SUB;
    else if (aluop[1]) begin
      case (f3)
        F3_ADD:  alu_decode = (aluop == 2'b10 && f7b5) ? ALU_SUB : ALU_ADD;
        F3_SLL:  alu_decode = ALU_SLL;
        F3_SLT:  alu_decode = ALU_SLT;
        F3_XOR:  alu_decode = ALU_XOR;
        F3_SR:   alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
        F3_OR:   alu_decode = ALU_OR;
        F3_AND:  alu_decode = ALU_AND;
        default: alu_decode = ALU_ADD;
      endcase
    end
  endfunction

  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return (rd != '0) && (rd == a || rd == b);
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two async read ports, one write port, write-first bypass, x0 hard zero.
module riscv_regfile (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/riscv_pipeline.sv
// Five-stage RV32I-subset core with ROM/RAM and LED/SSD debug taps.
// FORWARD_EN: EX-operand forwarding with load-use stall only; otherwise stall on any EX/MEM producer.
module riscv_pipeline import riscv_pkg::*; #(
  parameter IMEM_FILE = "imem.hex",
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ledSel,
  input  logic [3:0]  ssdSel,
  output logic [7:0]  leds,
  output logic [12:0] ssd
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] imem [MEM_WORDS];
  logic [31:0] dmem [MEM_WORDS];

  ifid_t  ifid;
  idex_t  idex, idex_d;
  exmem_t exmem;
  memwb_t memwb;

  logic [31:0] pc, pc_plus4, pc_next, instr_if;
  logic [31:0] instr_id, imm_id, rs1d_id, rs2d_id, wb_data, dram_rd;
  logic [31:0] op_a, op_b, alu_b, alu_y, br_target, ex_res;
  logic [4:0]  rs1_id, rs2_id;
  ctrl_t       ctrl_id;
  alu_op_e     alu_op;
  logic        stall, taken;

  // IF
  assign instr_if = imem[pc[AW+1:2]];
  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = taken ? br_target : stall ? pc : pc_plus4;

  // ID
  assign instr_id = ifid.instr;
  assign rs1_id   = instr_id[19:15];
  assign rs2_id   = instr_id[24:20];

  always_comb begin
    ctrl_id = '0;
    imm_id  = {{20{instr_id[31]}}, instr_id[31:20]};
    case (instr_id[6:0])
      OP_R:   begin ctrl_id.regwrite = 1'b1; ctrl_id.aluop = 2'b10; end
      OP_IMM: begin ctrl_id.alusrc = 1'b1; ctrl_id.regwrite = 1'b1; ctrl_id.aluop = 2'b11; end
      OP_LOAD: begin
        ctrl_id.memread = 1'b1; ctrl_id.memtoreg = 1'b1;
        ctrl_id.alusrc = 1'b1;  ctrl_id.regwrite = 1'b1;
      end
      OP_STORE: begin
        ctrl_id.memwrite = 1'b1; ctrl_id.alusrc = 1'b1;
        imm_id = {{20{instr_id[31]}}, instr_id[31:25], instr_id[11:7]};
      end
      OP_BRANCH: begin
        ctrl_id.branch = (instr_id[14:12] == F3_ADD);
        ctrl_id.aluop  = 2'b01;
        imm_id = {{19{instr_id[31]}}, instr_id[31], instr_id[7], instr_id[30:25],
                  instr_id[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl_id.jump = 1'b1; ctrl_id.regwrite = 1'b1;
        imm_id = {{11{instr_id[31]}}, instr_id[31], instr_id[19:12], instr_id[20],
                  instr_id[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  riscv_regfile u_rf (
    .gclk(clk), .grst_n(rst),
    .ra1(rs1_id), .ra2(rs2_id),
    .we(memwb.regwrite), .wa(memwb.rd), .wd(wb_data),
    .rd1(rs1d_id), .rd2(rs2d_id)
  );

`ifdef FORWARD_EN
  assign stall = idex.ctrl.memread && rd_hit(idex.rd, rs1_id, rs2_id);
`else
  // WB producers are covered by the register file's write-first bypass
  assign stall = (idex.ctrl.regwrite && rd_hit(idex.rd, rs1_id, rs2_id)) ||
                 (exmem.regwrite && rd_hit(exmem.rd, rs1_id, rs2_id));
`endif

  always_comb begin
    idex_d          = '0;
    idex_d.ctrl     = ctrl_id;
    idex_d.pc       = ifid.pc;
    idex_d.rs1d     = rs1d_id;
    idex_d.rs2d     = rs2d_id;
    idex_d.imm      = imm_id;
`ifdef FORWARD_EN
    idex_d.rs1      = rs1_id;
    idex_d.rs2      = rs2_id;
`endif
    idex_d.rd       = instr_id[11:7];
    idex_d.funct3   = instr_id[14:12];
    idex_d.funct7b5 = instr_id[30];
  end

  // EX
`ifdef FORWARD_EN
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf_val);
    if (exmem.regwrite && exmem.rd != '0 && exmem.rd == rs) return exmem.res;
    if (memwb.regwrite && memwb.rd != '0 && memwb.rd == rs) return wb_data;
    return rf_val;
  endfunction
  assign op_a = fwd(idex.rs1, idex.rs1d);
  assign op_b = fwd(idex.rs2, idex.rs2d);
`else
  assign op_a = idex.rs1d;
  assign op_b = idex.rs2d;
`endif

  assign alu_b  = idex.ctrl.alusrc ? idex.imm : op_b;
  assign alu_op = alu_decode(idex.ctrl.aluop, idex.funct3, idex.funct7b5);

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = op_a - alu_b;
      ALU_AND: alu_y = op_a & alu_b;
      ALU_OR:  alu_y = op_a | alu_b;
      ALU_XOR: alu_y = op_a ^ alu_b;
      ALU_SLL: alu_y = op_a << alu_b[4:0];
      ALU_SRL: alu_y = op_a >> alu_b[4:0];
      ALU_SRA: alu_y = $signed(op_a) >>> alu_b[4:0];
      ALU_SLT: alu_y = {31'd0, $signed(op_a) < $signed(alu_b)};
      default: alu_y = op_a + alu_b;
    endcase
  end

  assign br_target = idex.pc + idex.imm;
  assign taken     = idex.ctrl.jump || (idex.ctrl.branch && op_a == op_b);
  assign ex_res    = idex.ctrl.jump ? idex.pc + 32'd4 : alu_y;

  // MEM / WB
  assign dram_rd = exmem.memread ? dmem[exmem.res[AW+1:2]] : '0;
  assign wb_data = memwb.memtoreg ? memwb.rdata : memwb.res;

  always_ff @(posedge clk) begin
    if (exmem.memwrite) dmem[exmem.res[AW+1:2]] <= exmem.rs2d;
  end

  // Redirect flush outranks the load-use stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      ifid  <= '{pc: '0, instr: NOP};
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      pc <= pc_next;
      if (taken)       ifid <= '{pc: '0, instr: NOP};
      else if (!stall) ifid <= '{pc: pc, instr: instr_if};
      idex  <= (taken || stall) ? '0 : idex_d;
      exmem <= '{regwrite: idex.ctrl.regwrite, memtoreg: idex.ctrl.memtoreg,
                 memread: idex.ctrl.memread, memwrite: idex.ctrl.memwrite,
                 res: ex_res, rs2d: op_b, rd: idex.rd};
      memwb <= '{regwrite: exmem.regwrite, memtoreg: exmem.memtoreg,
                 res: exmem.res, rdata: dram_rd, rd: exmem.rd};
    end
  end

  // Debug taps
  always_comb begin
    case (ledSel)
      2'd0:    leds = ifid.instr[7:0];
      2'd1:    leds = ifid.instr[15:8];
      2'd2:    leds = ifid.instr[23:16];
      default: leds = {ctrl_id.branch, ctrl_id.memread, ctrl_id.memtoreg, ctrl_id.memwrite,
                       ctrl_id.alusrc, ctrl_id.regwrite, ctrl_id.aluop};
    endcase
  end

  always_comb begin
    case (ssdSel)
      4'd0:    ssd = pc[12:0];
      4'd1:    ssd = pc_plus4[12:0];
      4'd2:    ssd = br_target[12:0];
      4'd3:    ssd = pc_next[12:0];
      4'd4:    ssd = rs1d_id[12:0];
      4'd5:    ssd = rs2d_id[12:0];
      4'd6:    ssd = wb_data[12:0];
      4'd7:    ssd = imm_id[12:0];
      4'd8:    ssd = idex.imm[12:0];
      4'd9:    ssd = alu_b[12:0];
      4'd10:   ssd = alu_y[12:0];
      4'd11:   ssd = dram_rd[12:0];
      default: ssd = '0;
    endcase
  end

endmodule

// File: tb/tb_riscv_pipeline.sv
// Directed-program bench for riscv_pipeline; builds with or without FORWARD_EN.
module tb_riscv_pipeline;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ledSel = 2'd0;
  logic [3:0]  ssdSel = 4'd0;
  logic [7:0]  leds;
  logic [12:0] ssd;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] prog [$];

  riscv_pipeline dut (
    .clk(clk), .rst(rst), .ledSel(ledSel), .ssdSel(ssdSel), .leds(leds), .ssd(ssd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.u_rf.regs[i];
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] rop(input int f7, input int f3, input int rd, input int rs1,
                                      input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    logic [11:0] i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] beq(input int rs1, input int rs2, input int imm);
    logic [12:0] i = 13'(imm);
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [20:0] i = 21'(imm);
    return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic put(input logic [31:0] w);
    prog.push_back(w);
  endtask

  // Reset, load ROM while held, release on a falling edge so the next rise is edge 1
  task automatic start();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : NOP_I;
    prog.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic look_ssd(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    ssdSel = sel;
    #1;
    chk(tag, 32'(ssd), exp);
  endtask

  task automatic look_led(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    ledSel = sel;
    #1;
    chk(tag, 32'(leds), exp);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    look_ssd("rst_pc", 4'd0, 32'h0);
    look_ssd("rst_pc4", 4'd1, 32'h4);
    look_ssd("rst_npc", 4'd3, 32'h4);
    look_led("rst_led0", 2'd0, 32'h13);
    look_led("rst_ctrl", 2'd3, 32'h0f);
    ledSel = 2'd0;
    ssdSel = 4'd0;

    // ALU chain
    put(addi(1, 0, 5)); put(addi(2, 0, 7));
    put(rop(0, 0, 3, 1, 2)); put(rop(32, 0, 4, 3, 1)); put(jal(0, 0));
    start();
    step(4);
    chk("x1_edge4", rf(1), 32'd0);
    step(1);
    chk("x1_edge5", rf(1), 32'd5);
    step(2);
`ifdef FORWARD_EN
    chk("x3_edge7", rf(3), 32'd12);
`else
    chk("x3_edge7", rf(3), 32'd0);
`endif
    step(30);
    chk("chain_x2", rf(2), 32'd7);
    chk("chain_x3", rf(3), 32'd12);
    chk("chain_x4", rf(4), 32'd7);

    // asynchronous reset mid-program
    rst = 1'b0;
    #1;
    chk("arst_x3", rf(3), 32'd0);
    look_ssd("arst_pc", 4'd0, 32'h0);
    look_led("arst_led", 2'd0, 32'h13);

    // load-use
    put(addi(3, 0, 12)); put(sw(3, 0, 8)); put(lw(5, 0, 8));
    put(rop(0, 0, 6, 5, 5)); put(jal(0, 0));
    start();
`ifdef FORWARD_EN
    step(8);
    chk("lu_x6_edge8", rf(6), 32'd0);
    step(1);
    chk("lu_x6_edge9", rf(6), 32'd24);
`endif
    step(30);
    chk("lu_x5", rf(5), 32'd12);
    chk("lu_x6", rf(6), 32'd24);
    chk("lu_dmem", dut.dmem[2], 32'd12);

    // taken branch skips one instruction
    put(addi(1, 0, 1)); put(beq(1, 1, 8)); put(addi(7, 0, 9));
    put(addi(8, 0, 3)); put(jal(0, 0));
    start();
    step(30);
    chk("br_x7", rf(7), 32'd0);
    chk("br_x8", rf(8), 32'd3);

    // JAL at 0x10 flushes two fetched instructions
    for (int i = 0; i < 4; i++) put(NOP_I);
    put(jal(1, 12)); put(addi(10, 0, 1)); put(addi(11, 0, 1));
    put(addi(12, 0, 7)); put(jal(0, 0));
    start();
    step(6);
    look_ssd("jal_pc", 4'd0, 32'h18);
    look_ssd("jal_tgt", 4'd2, 32'h1c);
    look_ssd("jal_npc", 4'd3, 32'h1c);
    step(1);
    look_ssd("jal_pc_after", 4'd0, 32'h1c);
    look_led("jal_flush", 2'd0, 32'h13);
    step(30);
    chk("jal_x1", rf(1), 32'h14);
    chk("jal_x10", rf(10), 32'd0);
    chk("jal_x11", rf(11), 32'd0);
    chk("jal_x12", rf(12), 32'd7);

    // ALU operation mix
    put(addi(1, 0, -8)); put(addi(2, 0, 10));
    put(rop(0, 1, 3, 1, 2)); put(rop(0, 5, 4, 1, 2)); put(rop(32, 5, 5, 1, 2));
    put(rop(0, 2, 6, 1, 2)); put(rop(0, 7, 7, 1, 2)); put(rop(0, 6, 8, 1, 2));
    put(rop(0, 4, 9, 1, 2)); put(rop(0, 2, 10, 2, 1)); put(rop(32, 0, 11, 2, 1));
    put(jal(0, 0));
    start();
    step(50);
    chk("mix_sll", rf(3), 32'hffff_e000);
    chk("mix_srl", rf(4), 32'h003f_ffff);
    chk("mix_sra", rf(5), 32'hffff_ffff);
    chk("mix_slt", rf(6), 32'd1);
    chk("mix_and", rf(7), 32'h0000_0008);
    chk("mix_or", rf(8), 32'hffff_fffa);
    chk("mix_xor", rf(9), 32'hffff_fff2);
    chk("mix_slt0", rf(10), 32'd0);
    chk("mix_sub", rf(11), 32'h0000_0012);

    // writes to x0 are discarded
    put(addi(0, 0, 5)); put(rop(0, 0, 9, 0, 0)); put(addi(13, 0, 3)); put(jal(0, 0));
    start();
    step(30);
    chk("x0_store", rf(0), 32'd0);
    chk("x0_x9", rf(9), 32'd0);
    chk("x0_x13", rf(13), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
